// File: rtl/audio_sd_dac2.sv
// audio_sd_dac2: second-order sigma-delta audio DAC with linear interpolation and mute fade
module audio_sd_dac2 #(
  parameter int WIDTH       = 6,
  parameter int INTERP_LOG2 = 4
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic [WIDTH-1:0] audio_in,
  input  logic             mute,
  output logic             dac_out,
  output logic             sample_tick
);
  localparam int N   = WIDTH + INTERP_LOG2;
  localparam int ACC = N + 4;
  localparam logic [WIDTH-1:0]      MID     = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [N-1:0]          CUR_RST = {MID, {INTERP_LOG2{1'b0}}};
  localparam logic signed [ACC:0]   FS      = (ACC+1)'(2**N - 1);
  localparam logic signed [ACC:0]   SMAX    = (ACC+1)'(2**(ACC-2) - 1);
  localparam logic signed [ACC:0]   SMIN    = (ACC+1)'(-(2**(ACC-2)));
  logic [WIDTH-1:0]        audio_q;
  logic [INTERP_LOG2-1:0]  ph_q;
  logic signed [WIDTH:0]   delta_q, delta_d;
  logic [N-1:0]            cur_q, cur_d;
  logic signed [N+1:0]     cur_sum;
  logic signed [ACC-1:0]   i1_q, i1_d, i2_q, i2_d;
  logic signed [ACC:0]     fb;
  logic [WIDTH-1:0]        tgt;
  logic                    cap, dac_q, tick_q;
  function automatic logic signed [ACC-1:0] sat(input logic signed [ACC:0] x);
    return x > SMAX ? SMAX[ACC-1:0] : x < SMIN ? SMIN[ACC-1:0] : x[ACC-1:0];
  endfunction
  // delta is taken against cur after this cycle's addition, so each ramp lands exactly on its target
  always_comb begin
    cap     = ph_q == {INTERP_LOG2{1'b1}};
    tgt     = mute ? MID : audio_q;
    cur_sum = $signed({2'b00, cur_q}) + (N+2)'(delta_q);
    cur_d   = cur_sum[N+1] ? '0 : cur_sum[N] ? '1 : cur_sum[N-1:0];
    delta_d = cap ? $signed({1'b0, tgt}) - $signed({1'b0, cur_d[N-1:INTERP_LOG2]}) : delta_q;
    fb      = dac_q ? FS : '0;
    i1_d    = sat((ACC+1)'(i1_q) + (ACC+1)'($signed({1'b0, cur_q})) - fb);
    i2_d    = sat((ACC+1)'(i2_q) + (ACC+1)'(i1_d) - fb);
  end
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      audio_q <= '0;
      ph_q    <= '0;
      delta_q <= '0;
      cur_q   <= CUR_RST;
      i1_q    <= '0;
      i2_q    <= '0;
      dac_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      audio_q <= audio_in;
      ph_q    <= ph_q + 1'b1;
      delta_q <= delta_d;
      cur_q   <= cur_d;
      i1_q    <= i1_d;
      i2_q    <= i2_d;
      dac_q   <= ~i2_d[ACC-1];
      tick_q  <= cap;
    end
  end
  assign dac_out     = dac_q;
  assign sample_tick = tick_q;
endmodule
